br_cond_ctrl: RTL

Conditional-branch controller that sits directly downstream of the integer-compare operator. It consumes the 1-bit compare result through a valid/ready handshake, buffers it in a small FIFO, and issues the successor basic-block ID plus a one-cycle enable to the taken or not-taken successor. It is the `br i1 %cond, label %T, label %F` terminator of a generated basic block.

---
 rtl/br_cond_ctrl_pkg.sv | 22 ++
 rtl/br_cond_ctrl_if.sv | 46 ++++
 rtl/br_cond_ctrl_fifo.sv | 70 +++++++
 rtl/br_cond_ctrl.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/br_cond_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : hdbe_ctrl_pkg                                                |
// | Description : Shared types and helpers for generated terminator blocks.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package hdbe_ctrl_pkg;

    localparam int c_def_id_width = 8;

    typedef enum logic [0:0] {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    // Occupancy needs one extra bit so that "full" is distinguishable from "empty".
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/br_cond_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : br_cond_ctrl_if                                              |
// | Description : Compare-result input and successor-issue output bundle.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface br_cond_ctrl_if
    import hdbe_ctrl_pkg::*;
#(
    parameter int ParamIdWidth = c_def_id_width
) ();

    logic                    cond_valid;
    logic                    cond;
    logic                    cond_ready;
    logic                    succ_valid;
    logic [ParamIdWidth-1:0] succ_id;
    logic                    succ_ready;
    logic                    true_enable;
    logic                    false_enable;

    // Environment side: compare stage upstream plus successor scheduler downstream.
    modport master (
        output cond_valid,
        output cond,
        output succ_ready,
        input  cond_ready,
        input  succ_valid,
        input  succ_id,
        input  true_enable,
        input  false_enable
    );

    modport slave (
        input  cond_valid,
        input  cond,
        input  succ_ready,
        output cond_ready,
        output succ_valid,
        output succ_id,
        output true_enable,
        output false_enable
    );

endinterface
`default_nettype wire

// File: rtl/br_cond_ctrl_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : br_cond_fifo                                                 |
// | Description : 1-bit-wide synchronous FIFO with occupancy count.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module br_cond_fifo
    import hdbe_ctrl_pkg::*;
#(
    parameter int ParamFifoDepth = 2
) (
    input  wire logic                                   clk,
    input  wire logic                                   reset,
    input  wire logic                                   push,
    input  wire logic                                   din,
    input  wire logic                                   pop,
    output logic                                        dout,
    output logic                                        full,
    output logic                                        empty,
    output logic [occ_width(ParamFifoDepth)-1:0]        count
);

    localparam int c_ptr_w = $clog2(ParamFifoDepth);
    localparam int c_cnt_w = occ_width(ParamFifoDepth);

    logic [ParamFifoDepth-1:0] r_mem;
    logic [c_ptr_w-1:0]        r_wr_ptr;
    logic [c_ptr_w-1:0]        r_rd_ptr;
    logic [c_cnt_w-1:0]        r_count;
    logic                      w_push;
    logic                      w_pop;

    // Requests that would overflow or underflow are dropped here as a safety net.
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Depth is a power of two, so natural pointer overflow gives the modulo wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = (r_count == c_cnt_w'(ParamFifoDepth));
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/br_cond_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : br_cond_ctrl                                                 |
// | Description : Conditional-branch terminator: buffers compare results and   |
// |               issues the taken / not-taken successor ID with a pulse.      |
// |               Define BR_COND_STATS_EN to add saturating branch counters.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module br_cond_ctrl
    import hdbe_ctrl_pkg::*;
#(
    parameter int ParamIdWidth   = c_def_id_width,
    parameter int ParamTrueId    = 1,
    parameter int ParamFalseId   = 2,
    parameter int ParamFifoDepth = 2
`ifdef BR_COND_STATS_EN
    ,
    parameter int ParamCntWidth  = 32
`endif
) (
    input  wire logic                clk,
    input  wire logic                reset,
    input  wire logic                enable,
    br_cond_ctrl_if.slave            bus
`ifdef BR_COND_STATS_EN
    ,
    output logic [ParamCntWidth-1:0] taken_count,
    output logic [ParamCntWidth-1:0] not_taken_count
`endif
);

    localparam logic [ParamIdWidth-1:0] c_true_id  = ParamIdWidth'(ParamTrueId);
    localparam logic [ParamIdWidth-1:0] c_false_id = ParamIdWidth'(ParamFalseId);

    out_state_t                              r_state;
    out_state_t                              w_state_nxt;
    logic                                    r_cond;
    logic                                    w_cond_ready;
    logic                                    w_fifo_push;
    logic                                    w_fifo_pop;
    logic                                    w_fifo_dout;
    logic                                    w_fifo_full;
    logic                                    w_fifo_empty;
    logic [occ_width(ParamFifoDepth)-1:0]    w_fifo_count;
    logic                                    w_unused_count;
    logic                                    w_handshake;
    logic                                    w_true_en;
    logic                                    w_false_en;

    // Ready looks only at registered occupancy, so a full FIFO never passes through.
    assign w_cond_ready = !reset && enable && !w_fifo_full;
    assign w_fifo_push  = bus.cond_valid && w_cond_ready;

    br_cond_fifo #(
        .ParamFifoDepth (ParamFifoDepth)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_fifo_push),
        .din   (bus.cond),
        .pop   (w_fifo_pop),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

    assign w_unused_count = ^w_fifo_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= OUT_EMPTY;
            r_cond  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_fifo_pop) begin
                r_cond <= w_fifo_dout;
            end
        end
    end

    // Every pop reloads the output register; a pop only happens when the slot is free.
    always_comb begin
        w_state_nxt = r_state;
        w_fifo_pop  = 1'b0;
        case (r_state)
            OUT_EMPTY: begin
                if (enable && !w_fifo_empty) begin
                    w_fifo_pop  = 1'b1;
                    w_state_nxt = OUT_FULL;
                end
            end
            OUT_FULL: begin
                if (enable && bus.succ_ready) begin
                    if (!w_fifo_empty) begin
                        w_fifo_pop = 1'b1;
                    end else begin
                        w_state_nxt = OUT_EMPTY;
                    end
                end
            end
            default: begin
                w_state_nxt = OUT_EMPTY;
            end
        endcase
    end

    // Reset masks the issue side so no handshake completes during a flush.
    assign w_handshake = !reset && (r_state == OUT_FULL) && enable && bus.succ_ready;
    assign w_true_en   = w_handshake && r_cond;
    assign w_false_en  = w_handshake && !r_cond;

    assign bus.cond_ready   = w_cond_ready;
    assign bus.succ_valid   = !reset && (r_state == OUT_FULL);
    assign bus.succ_id      = r_cond ? c_true_id : c_false_id;
    assign bus.true_enable  = w_true_en;
    assign bus.false_enable = w_false_en;

`ifdef BR_COND_STATS_EN
    logic [ParamCntWidth-1:0] r_taken_cnt;
    logic [ParamCntWidth-1:0] r_not_taken_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_taken_cnt     <= '0;
            r_not_taken_cnt <= '0;
        end else begin
            if (w_true_en && !(&r_taken_cnt)) begin
                r_taken_cnt <= r_taken_cnt + ParamCntWidth'(1);
            end
            if (w_false_en && !(&r_not_taken_cnt)) begin
                r_not_taken_cnt <= r_not_taken_cnt + ParamCntWidth'(1);
            end
        end
    end

    assign taken_count     = r_taken_cnt;
    assign not_taken_count = r_not_taken_cnt;
`endif

endmodule
`default_nettype wire
